// File: rtl/mem_access_ctrl.sv
// Load/store initiator: validates a byte address and drives the data memory's
// edge-triggered read/write strobes with one cycle of setup and hold around each pulse.
module mem_access_ctrl #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              isWrite,
    input  logic [31:0]       reqAddr,
    input  logic [DATA_W-1:0] reqWData,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rData,
    output logic [ADDR_W-1:0] memAddress,
    output logic [DATA_W-1:0] memWriteData,
    output logic              memTrigWrite,
    output logic              memTrigRead,
    input  logic [DATA_W-1:0] memReadData
);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StStrobe,
        StHold,
        StFail
    } state_e;

    state_e state_q;
    logic   write_q;
    logic   addr_ok;

    // Word aligned and inside the memory's word range.
    assign addr_ok = (reqAddr[1:0] == 2'b00) && (reqAddr[31:ADDR_W+2] == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            write_q      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            rData        <= '0;
            memAddress   <= '0;
            memWriteData <= '0;
            memTrigWrite <= 1'b0;
            memTrigRead  <= 1'b0;
        end else begin
            done         <= 1'b0;
            err          <= 1'b0;
            memTrigWrite <= 1'b0;
            memTrigRead  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req) begin
                        busy    <= 1'b1;
                        write_q <= isWrite;
                        if (addr_ok) begin
                            state_q    <= StSetup;
                            memAddress <= reqAddr[ADDR_W+1:2];
                            if (isWrite) begin
                                memWriteData <= reqWData;
                            end
                        end else begin
                            state_q <= StFail;
                        end
                    end
                end
                StSetup: begin
                    state_q      <= StStrobe;
                    memTrigWrite <= write_q;
                    memTrigRead  <= ~write_q;
                end
                StStrobe: begin
                    state_q <= StHold;
                end
                StHold: begin
                    // Memory has had a full cycle since the read strobe edge.
                    if (!write_q) begin
                        rData <= memReadData;
                    end
                    state_q <= StIdle;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                end
                StFail: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    err     <= 1'b1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with an edge-triggered word memory model.
module tb_mem_access_ctrl;

    logic        clk;
    logic        reset;
    logic        req;
    logic        isWrite;
    logic [31:0] reqAddr;
    logic [31:0] reqWData;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rData;
    logic [6:0]  memAddress;
    logic [31:0] memWriteData;
    logic        memTrigWrite;
    logic        memTrigRead;
    logic [31:0] memReadData;

    int n_checks = 0;
    int n_errors = 0;
    int rd_edges = 0;
    int wr_edges = 0;
    int overlap  = 0;

    logic [31:0] mem [128];
    bit   [127:0] written;

    mem_access_ctrl #(
        .ADDR_W (7),
        .DATA_W (32)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .isWrite      (isWrite),
        .reqAddr      (reqAddr),
        .reqWData     (reqWData),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .rData        (rData),
        .memAddress   (memAddress),
        .memWriteData (memWriteData),
        .memTrigWrite (memTrigWrite),
        .memTrigRead  (memTrigRead),
        .memReadData  (memReadData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] preload(input logic [6:0] a);
        case (a)
            7'd0:    return 32'd10;
            7'd1:    return 32'd22;
            7'd2:    return 32'd6;
            default: return 32'h1000 + {25'b0, a};
        endcase
    endfunction

    always @(posedge memTrigWrite) begin
        mem[memAddress]     <= memWriteData;
        written[memAddress] <= 1'b1;
        wr_edges++;
    end

    always @(posedge memTrigRead) begin
        memReadData <= written[memAddress] ? mem[memAddress] : preload(memAddress);
        rd_edges++;
    end

    always @(negedge clk) begin
        if (memTrigRead && memTrigWrite) overlap++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One access; traces hold per-cycle samples indexed by cycles after the accept edge.
    task automatic do_access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                             output int lat, output logic e, output logic [15:0] rtr,
                             output logic [15:0] wtr, output logic [15:0] btr,
                             output logic [6:0] a1);
        @(negedge clk);
        req = 1'b1; isWrite = wr; reqAddr = addr; reqWData = wdata;
        @(posedge clk);
        #1 req = 1'b0;
        lat = 0; e = 1'b0; rtr = '0; wtr = '0; btr = '0; a1 = '0;
        for (int k = 1; k < 12; k++) begin
            @(negedge clk);
            rtr[k] = memTrigRead;
            wtr[k] = memTrigWrite;
            btr[k] = busy;
            if (k == 1) a1 = memAddress;
            if (done) begin
                lat = k;
                e   = err;
                break;
            end
        end
    endtask

    int          lat;
    logic        e;
    logic [15:0] rtr, wtr, btr;
    logic [6:0]  a1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          ev0;
        int          dones;
        int          bad;
        logic [31:0] dmask;

        reset = 1'b1; req = 1'b1; isWrite = 1'b0; reqAddr = 32'h4; reqWData = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_trig", {memTrigRead, memTrigWrite}, 0);
        check_eq("rst_addr", memAddress, 0);
        check_eq("rst_wdata", memWriteData, 0);
        check_eq("rst_rdata", rData, 0);
        check_eq("rst_edges", rd_edges + wr_edges, 0);
        reset = 1'b0; req = 1'b0;

        do_access(1'b1, 32'h0C, 32'h1234ABCD, lat, e, rtr, wtr, btr, a1);
        check_eq("st_lat", lat, 4);
        check_eq("st_err", e, 0);
        check_eq("st_addr", a1, 3);
        check_eq("st_wtr", wtr, 16'h0004);
        check_eq("st_rtr", rtr, 16'h0000);
        check_eq("st_busy", btr, 16'h000E);
        check_eq("st_wdata", memWriteData, 32'h1234ABCD);

        do_access(1'b0, 32'h0C, 32'h0, lat, e, rtr, wtr, btr, a1);
        check_eq("ld_lat", lat, 4);
        check_eq("ld_rtr", rtr, 16'h0004);
        check_eq("ld_wtr", wtr, 16'h0000);
        check_eq("ld_rdata", rData, 32'h1234ABCD);

        do_access(1'b0, 32'h04, 32'h0, lat, e, rtr, wtr, btr, a1);
        check_eq("pl_addr", a1, 1);
        check_eq("pl_rtr", rtr, 16'h0004);
        check_eq("pl_rdata", rData, 22);

        do_access(1'b1, 32'h08, 32'h55AA55AA, lat, e, rtr, wtr, btr, a1);
        check_eq("st2_wtr", wtr, 16'h0004);
        check_eq("st2_rdata", rData, 22);

        do_access(1'b0, 32'h1FC, 32'h0, lat, e, rtr, wtr, btr, a1);
        check_eq("top_addr", a1, 127);
        check_eq("top_err", e, 0);
        check_eq("top_rdata", rData, 32'h107F);

        do_access(1'b0, 32'h06, 32'h0, lat, e, rtr, wtr, btr, a1);
        check_eq("rj1_lat", lat, 2);
        check_eq("rj1_err", e, 1);
        check_eq("rj1_trig", rtr | wtr, 0);
        check_eq("rj1_busy", btr, 16'h0002);
        check_eq("rj1_rdata", rData, 32'h107F);
        check_eq("rj1_addr", memAddress, 127);

        do_access(1'b1, 32'h200, 32'hFFFF0000, lat, e, rtr, wtr, btr, a1);
        check_eq("rj2_lat", lat, 2);
        check_eq("rj2_err", e, 1);
        check_eq("rj2_trig", rtr | wtr, 0);
        check_eq("rj2_wdata", memWriteData, 32'h55AA55AA);
        check_eq("rj2_addr", memAddress, 127);

        // Continuous request: one access per 4 cycles.
        ev0 = rd_edges; dmask = '0; bad = 0;
        @(negedge clk);
        req = 1'b1; isWrite = 1'b0; reqAddr = 32'h0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (done) begin
                dmask[k] = 1'b1;
                if (rData !== 32'd10) bad++;
            end
            if (k == 16) req = 1'b0;
        end
        check_eq("b2b_done", dmask, 32'h0001_1110);
        check_eq("b2b_rdata", bad, 0);
        check_eq("b2b_edges", rd_edges - ev0, 4);

        // Request pulse during STROBE is ignored.
        ev0 = rd_edges; dones = 0;
        @(negedge clk);
        req = 1'b1; isWrite = 1'b0; reqAddr = 32'h04;
        @(posedge clk);
        #1 req = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 2) req = 1'b1;
            if (k == 3) req = 1'b0;
            if (done) dones++;
        end
        check_eq("ign_done", dones, 1);
        check_eq("ign_edges", rd_edges - ev0, 1);
        check_eq("ign_rdata", rData, 22);

        // Reset while the write strobe is high.
        ev0 = wr_edges; dones = 0;
        @(negedge clk);
        req = 1'b1; isWrite = 1'b1; reqAddr = 32'h08; reqWData = 32'hCAFEF00D;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("mid_strobe", memTrigWrite, 1);
        reset = 1'b1;
        @(negedge clk);
        check_eq("mid_trig", memTrigWrite, 0);
        check_eq("mid_busy", busy, 0);
        check_eq("mid_addr", memAddress, 0);
        check_eq("mid_wdata", memWriteData, 0);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check_eq("mid_nodone", dones, 0);
        check_eq("mid_edges", wr_edges - ev0, 1);

        do_access(1'b0, 32'h08, 32'h0, lat, e, rtr, wtr, btr, a1);
        check_eq("post_lat", lat, 4);
        check_eq("post_rdata", rData, 32'hCAFEF00D);

        check_eq("overlap", overlap, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
